// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and the default bit timing.
// Used by both the receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so a released reset never looks like a falling edge.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN to use 2-of-3 majority sampling around each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // With majority voting the start decision lands one cycle later; the data
    // and stop decisions then keep a whole-bit spacing from it.
    localparam logic [CW-1:0] START_TGT = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
    localparam logic [CW-1:0] BIT_TGT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 bit_val;
    logic                 shift_en;
    logic                 load;
    logic                 ferr;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_val = majority3(hist[1], hist[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_en   = 1'b0;
        load       = 1'b0;
        ferr       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                cnt_next = cnt + CW'(1);
                if (cnt == START_TGT) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_next = cnt + CW'(1);
                if (cnt == BIT_TGT) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            STOP: begin
                cnt_next = cnt + CW'(1);
                // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                if (cnt == BIT_TGT) begin
                    cnt_next = '0;
                    if (bit_val) begin
                        load       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr       = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= load && valid && !ready;
            if (load) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes and pulse counts,
// a negedge monitor pops and compares whenever a byte is handed over.
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         ferr_seen = 0;
    int         ferr_exp = 0;
    int         ovr_seen = 0;
    int         ovr_exp = 0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_period(input logic v);
        rx = v;
        cycles(C);
    endtask

    // Line-level frame: start bit, 8 data bits LSB first, then the stop bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_level);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(stop_level);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: actual=%0h required=none", data);
                end else begin
                    check("rx_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         w;

        rst_n = 1'b0;
        cycles(3);
        check("reset_data", {24'h0, data}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;
        cycles(3);

        // Frame 0xA5 with latency measurement
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                int n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!valid && n < 400);
                check("latency_window", {31'h0, (n >= 154 && n <= 156)}, 32'h1);
                check("busy_after_mid_stop", {31'h0, busy}, 32'h0);
                check("no_frame_err_a5", {31'h0, frame_err}, 32'h0);
            end
        join
        rx = 1'b1;
        cycles(2 * C);
        check("ferr_count_a5", ferr_seen, ferr_exp);

        // Short low glitch
        rx = 1'b0;
        cycles(5);
        check("glitch_busy_high", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        cycles(8);
        check("glitch_busy_low", {31'h0, busy}, 32'h0);
        cycles(2 * C);
        check("glitch_no_valid", {31'h0, valid}, 32'h0);

        // Framing error, long low, then a good frame
        ferr_exp++;
        send_frame(8'h3C, 1'b0);
        cycles(24);
        rx = 1'b1;
        cycles(2 * C);
        check("ferr_count_3c", ferr_seen, ferr_exp);
        check("no_valid_after_ferr", {31'h0, valid}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        cycles(2 * C);
        check("queue_empty_5a", exp_q.size(), 0);

        // Overrun with ready held low
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        cycles(C);
        check("hold_valid_11", {31'h0, valid}, 32'h1);
        check("hold_data_11", {24'h0, data}, 32'h11);
        ovr_exp++;
        send_frame(8'h22, 1'b1);
        cycles(C);
        check("overrun_count", ovr_seen, ovr_exp);
        check("hold_data_22", {24'h0, data}, 32'h22);
        check("hold_valid_22", {31'h0, valid}, 32'h1);
        exp_q.push_back(8'h22);
        ready = 1'b1;
        cycles(1);
        check("valid_drops", {31'h0, valid}, 32'h0);
        check("queue_empty_22", exp_q.size(), 0);

        // Back-to-back frames, no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        cycles(2 * C);
        check("queue_empty_b2b", exp_q.size(), 0);

        // Reset in the middle of a frame
        fork
            send_frame(8'hF0, 1'b1);
            begin
                cycles(60);
                check("busy_mid_frame", {31'h0, busy}, 32'h1);
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst_data", {24'h0, data}, 32'h0);
                check("midrst_valid", {31'h0, valid}, 32'h0);
                check("midrst_busy", {31'h0, busy}, 32'h0);
                check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
                check("midrst_overrun", {31'h0, overrun}, 32'h0);
            end
        join
        rx = 1'b1;
        rst_n = 1'b1;
        cycles(2 * C);
        check("post_rst_idle", {30'h0, busy, valid}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        cycles(2 * C);
        check("queue_empty_81", exp_q.size(), 0);

        // Random frames: random bytes, gaps, and occasional bad stop bits
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                ferr_exp++;
                send_frame(b, 1'b0);
                cycles($urandom_range(0, 30));
                rx = 1'b1;
                cycles(C);
            end else begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                rx = 1'b1;
                cycles($urandom_range(0, 2 * C));
            end
        end
        rx = 1'b1;

        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        cycles(2 * C);
        check("drain_queue", exp_q.size(), 0);
        check("ferr_total", ferr_seen, ferr_exp);
        check("overrun_total", ovr_seen, ovr_exp);
        check("final_idle", {31'h0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
